// File: rtl/uart_tx_frame_16.sv
// uart_tx_frame_16: 16-bit word UART transmitter with a one-entry holding register.
// A word is sent as two byte-sized groups in one 23-bit-period frame:
//   start(0) | d[7:0] LSB first | stop,stop | separator(0) | d[15:8] LSB first | stop,stop | final stop
// Every bit lasts OVERSAMPLE clken ticks. Frames can run back-to-back with no idle gap.
module uart_tx_frame_16 #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clken,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int SW         = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int FRAME_BITS = 23;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                state_q, state_d;

  // Holding register: the word waiting for the line.
  logic                  hold_full_q;
  logic [DATA_WIDTH-1:0] hold_data_q;

  // Bits 1..22 of the frame still to go; the bit on the line lives in tx_q.
  logic [FRAME_BITS-2:0] shift_q;
  logic [SW-1:0]         sample_q;
  logic [4:0]            bit_idx_q;
  logic                  tx_q;
  logic                  tx_done_q;

  logic                  accept;
  logic                  last_sample;
  logic                  frame_end;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [FRAME_BITS-2:0] load_frame;

  assign in_ready    = ~hold_full_q;
  assign accept      = in_valid & in_ready;
  assign last_sample = (sample_q == SW'(OVERSAMPLE - 1));

  assign tx      = tx_q;
  assign busy    = (state_q == SEND);
  assign tx_done = tx_done_q;

  // Frame body above the start bit, bit 1 at the LSB.
  assign load_frame = {3'b111, load_data[15:8], 1'b0, 2'b11, load_data[7:0]};

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, frame-load decision and frame-end detection.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    frame_end = 1'b0;
    load_data = hold_data_q;
    case (state_q)
      IDLE: begin
        if (clken && hold_full_q) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (clken && last_sample && (bit_idx_q == 5'(FRAME_BITS - 1))) begin
          frame_end = 1'b1;
          // A word accepted on this very edge bypasses the empty holding register.
          if (hold_full_q || accept) begin
            load      = 1'b1;
            load_data = hold_full_q ? hold_data_q : data_in;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: filled on handshake, emptied when its word is loaded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_full_q <= 1'b1;
      hold_data_q <= data_in;
    end
  end

  // Bit timing and serialiser; tx comes straight from a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q   <= '1;
      sample_q  <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else if (load) begin
      shift_q   <= load_frame;
      sample_q  <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b0;
    end else if ((state_q == SEND) && clken) begin
      if (last_sample) begin
        sample_q <= '0;
        if (frame_end) begin
          bit_idx_q <= '0;
          tx_q      <= 1'b1;
        end else begin
          bit_idx_q <= bit_idx_q + 5'd1;
          tx_q      <= shift_q[0];
          shift_q   <= {1'b1, shift_q[FRAME_BITS-2:1]};
        end
      end else begin
        sample_q <= sample_q + SW'(1);
      end
    end
  end

  // One-clk completion pulse on the last tick of the final stop bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_done_q <= 1'b0;
    else       tx_done_q <= frame_end;
  end

endmodule
